// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller for the MEM stage. Loads that hit complete in the same cycle.
// Load misses refill the whole line one word per memory handshake. Every store
// is written through to memory, and a cached copy is updated only if the line
// is resident.
// Optional feature: define DCACHE_STATS_EN to enable the saturating load
// hit/miss counters. Without it, hit_count and miss_count are tied to zero.
//
// Handshakes:
//   cpu side: cpu_req with cpu_addr/cpu_we/cpu_wdata is held stable until the
//     cycle where cpu_ready=1. That cycle completes the access, and cpu_rdata
//     is valid then for loads.
//   mem side: mem_req with mem_we/mem_addr/mem_wdata is held stable until the
//     cycle where mem_ack=1. A transfer happens on the edge ending that cycle.
//     mem_rdata is sampled on that edge. mem_ack without mem_req is ignored.
module dcache_ctrl #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int WB  = $clog2(WORDS);
  localparam int OFF = 2 + WB;
  localparam int IDX = $clog2(LINES);
  localparam int TAG = 32 - IDX - OFF;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t            state;
  state_t            state_nx;
  logic [LINES-1:0]  valid;
  logic [TAG-1:0]    tag_mem  [LINES];
  logic [31:0]       data_mem [LINES*WORDS];
  logic [WB-1:0]     cnt;

  // Lookup for the CPU address.
  logic [IDX-1:0] cpu_idx;
  logic [TAG-1:0] cpu_tag;
  logic [WB-1:0]  cpu_word;
  logic           cpu_hit;

  // Lookup for the address currently presented to memory. Refill and
  // write-through work from this registered copy, so they complete even if
  // the CPU drops its request.
  logic [IDX-1:0] mem_idx;
  logic [TAG-1:0] mem_tag;
  logic [WB-1:0]  mem_word;
  logic           mem_hit;

  logic           ack_ok;
  logic           refill_last;
  logic           unused_addr_bits;

  assign cpu_idx     = cpu_addr[OFF +: IDX];
  assign cpu_tag     = cpu_addr[31 -: TAG];
  assign cpu_word    = cpu_addr[2 +: WB];
  assign cpu_hit     = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign cpu_rdata   = data_mem[{cpu_idx, cpu_word}];

  assign mem_idx     = mem_addr[OFF +: IDX];
  assign mem_tag     = mem_addr[31 -: TAG];
  assign mem_word    = mem_addr[2 +: WB];
  assign mem_hit     = valid[mem_idx] && (tag_mem[mem_idx] == mem_tag);

  assign ack_ok      = mem_req && mem_ack;
  assign refill_last = (state == REFILL) && ack_ok && (cnt == WB'(WORDS - 1));

  assign unused_addr_bits = ^cpu_addr[1:0];

  // Next-state decode and cpu_ready generation.
  always_comb begin
    state_nx  = state;
    cpu_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we)       state_nx  = WRITE;
          else if (cpu_hit) cpu_ready = 1'b1;
          else              state_nx  = REFILL;
        end
      end
      REFILL: begin
        if (refill_last) state_nx = IDLE;
      end
      WRITE: begin
        if (ack_ok) begin
          state_nx  = IDLE;
          cpu_ready = cpu_req;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!reset_n) cpu_ready = 1'b0;
  end

  // Control state: FSM register, valid bits, memory port and refill counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {cpu_addr[31:2], 2'b00};
              mem_wdata <= cpu_wdata;
            end else if (!cpu_hit) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {cpu_addr[31:OFF], {OFF{1'b0}}};
            end
          end
        end
        REFILL: begin
          if (ack_ok) begin
            if (refill_last) begin
              mem_req        <= 1'b0;
              valid[mem_idx] <= 1'b1;
              cnt            <= '0;
            end else begin
              mem_addr <= mem_addr + 32'd4;
              cnt      <= cnt + WB'(1);
            end
          end
        end
        WRITE: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays: refill words, install the tag on the last word, and
  // update a resident word on a completed write-through.
  always_ff @(posedge clk) begin
    if (reset_n && (state == REFILL) && ack_ok) begin
      data_mem[{mem_idx, cnt}] <= mem_rdata;
      if (refill_last) tag_mem[mem_idx] <= mem_tag;
    end
    if (reset_n && (state == WRITE) && ack_ok && mem_hit) begin
      data_mem[{mem_idx, mem_word}] <= mem_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;
  logic        just_filled;
  logic        load_idle;

  assign load_idle = (state == IDLE) && cpu_req && !cpu_we;

  // Saturating load hit/miss counters. The hit that completes a load right
  // after its own refill is not counted, because that load was already
  // counted as a miss.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_q       <= '0;
      miss_q      <= '0;
      just_filled <= 1'b0;
    end else begin
      just_filled <= refill_last;
      if (load_idle && cpu_hit && !just_filled && (hit_q != 32'hFFFF_FFFF))
        hit_q <= hit_q + 32'd1;
      if (load_idle && !cpu_hit && (miss_q != 32'hFFFF_FFFF))
        miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed test of dcache_ctrl at default parameters. It uses
// a scoreboard with separate CPU and memory expectation queues, and a memory
// model with a programmable ack delay.
module tb_dcache_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic        mem_ack_m = 1'b0;
  logic        spur_ack  = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  assign mem_ack = mem_ack_m | spur_ack;

  dcache_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [40:0] cpu_q[$];   // {is_load, wait_cycles[7:0], rdata}
  logic [64:0] mem_q[$];   // {we, addr, wdata}
  int exp_hits   = 0;
  int exp_misses = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_model [logic [31:0]];
  int ack_delay = 0;
  int mem_wait  = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h5A00_0000 | a;
  endfunction

  // Acks a request after ack_delay idle cycles; writes land in the model.
  always begin
    @(posedge clk);
    #1;
    mem_ack_m = 1'b0;
    if (mem_req) begin
      if (mem_wait >= ack_delay) begin
        mem_ack_m = 1'b1;
        mem_wait  = 0;
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else        mem_rdata = mem_read(mem_addr);
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
    end
  end

  // ---------------- monitors ----------------
  int          cpu_wait = 0;
  logic [40:0] cpu_e;

  // CPU side: measures stall cycles and checks each completed access.
  always @(negedge clk) begin
    if (!reset_n) begin
      cpu_wait = 0;
    end else if (cpu_req) begin
      if (cpu_ready) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_unexpected: got ready at addr %0h expected none", cpu_addr);
        end else begin
          cpu_e = cpu_q.pop_front();
          check("cpu_wait", 66'(cpu_wait), 66'(cpu_e[39:32]));
          if (cpu_e[40]) check("cpu_rdata", 66'(cpu_rdata), 66'(cpu_e[31:0]));
        end
        cpu_wait = 0;
      end else begin
        cpu_wait++;
      end
    end
  end

  logic [65:0] prev_mem;
  logic        prev_ok = 1'b0;
  logic [64:0] mem_e;

  // Memory side: outputs must hold while waiting; each handshake must match.
  always @(negedge clk) begin
    if (prev_ok && reset_n)
      check("mem_hold", {mem_req, mem_we, mem_addr, mem_wdata}, prev_mem);
    prev_mem = {mem_req, mem_we, mem_addr, mem_wdata};
    prev_ok  = reset_n && mem_req && !mem_ack;
    if (reset_n && mem_req && mem_ack) begin
      if (mem_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_unexpected: got access at %0h expected none", mem_addr);
      end else begin
        mem_e = mem_q.pop_front();
        check("mem_we", 66'(mem_we), 66'(mem_e[64]));
        check("mem_addr", 66'(mem_addr), 66'(mem_e[63:32]));
        if (mem_e[64]) check("mem_wdata", 66'(mem_wdata), 66'(mem_e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (cpu_ready) break;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL cpu_timeout: got no ready at addr %0h expected ready", cpu_addr);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] rd, input bit hit, input int lat);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_wdata = 32'd0;
    cpu_q.push_back({1'b1, 8'(lat), rd});
    if (hit) begin
      exp_hits++;
    end else begin
      exp_misses++;
      for (int i = 0; i < 4; i++)
        mem_q.push_back({1'b0, (a & 32'hFFFF_FFF0) + 32'(4 * i), 32'd0});
    end
    wait_ready();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    cpu_q.push_back({1'b0, 8'(lat), 32'd0});
    mem_q.push_back({1'b1, a & 32'hFFFF_FFFC, d});
    wait_ready();
  endtask

  task automatic check_counters(input string tag);
`ifdef DCACHE_STATS_EN
    check({tag, "_hit_count"}, 66'(hit_count), 66'(exp_hits));
    check({tag, "_miss_count"}, 66'(miss_count), 66'(exp_misses));
`else
    check({tag, "_hit_count"}, 66'(hit_count), 66'd0);
    check({tag, "_miss_count"}, 66'(miss_count), 66'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int acks;
    mem_model[32'h40] = 32'hA0;
    mem_model[32'h44] = 32'hA1;
    mem_model[32'h48] = 32'hA2;
    mem_model[32'h4C] = 32'hA3;

    // Reset with a load pending: no ready, memory port idle.
    reset_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", 66'(cpu_ready), 66'd0);
    check("rst_mem_req", 66'(mem_req), 66'd0);
    check("rst_mem_we", 66'(mem_we), 66'd0);
    check("rst_mem_addr", 66'(mem_addr), 66'd0);
    check("rst_mem_wdata", 66'(mem_wdata), 66'd0);
    check_counters("rst");
    @(posedge clk); #1;
    reset_n = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;

    // Miss refill then zero-wait hit.
    do_load(32'h40, 32'hA0, 1'b0, 5);
    do_load(32'h48, 32'hA2, 1'b1, 0);

    // Write-through on a cached line, then on an uncached line.
    do_store(32'h44, 32'h1234_5678, 1);
    do_load(32'h44, 32'h1234_5678, 1'b1, 0);
    do_store(32'h2000, 32'hCAFE_0001, 1);
    do_load(32'h2000, 32'hCAFE_0001, 1'b0, 5);

    // Alias on index 4: 0x440 evicts 0x40, which then misses again.
    do_load(32'h440, 32'h5A00_0440, 1'b0, 5);
    do_load(32'h40, 32'hA0, 1'b0, 5);
    do_load(32'h44, 32'h1234_5678, 1'b1, 0);
    check_counters("pre_reset");

    // Reset after the second refill ack of a miss.
    ack_delay = 1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    mem_q.push_back({1'b0, 32'h80, 32'd0});
    mem_q.push_back({1'b0, 32'h84, 32'd0});
    n = 0; acks = 0;
    while (acks < 2 && n < 100) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
      n++;
    end
    if (acks < 2) begin
      checks++; errors++;
      $display("FAIL refill_ack_timeout: got %0d acks expected 2", acks);
    end
    @(posedge clk); #1;
    reset_n = 1'b0; cpu_addr = 32'h48;
    @(negedge clk);
    check("midrst_cpu_ready", 66'(cpu_ready), 66'd0);
    @(negedge clk);
    check("midrst_mem_req", 66'(mem_req), 66'd0);
    check("midrst_mem_addr", 66'(mem_addr), 66'd0);
    exp_hits = 0; exp_misses = 0;
    check_counters("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1; cpu_req = 1'b0; ack_delay = 0;
    @(posedge clk); #1;
    do_load(32'h40, 32'hA0, 1'b0, 5);
    do_load(32'h48, 32'hA2, 1'b1, 0);

    // Spurious ack while idle: nothing moves.
    spur_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spur_ack = 1'b0;
    @(negedge clk);
    check("spur_mem_req", 66'(mem_req), 66'd0);
    check("spur_mem_addr", 66'(mem_addr), 66'h4C);
    @(posedge clk); #1;
    do_load(32'h48, 32'hA2, 1'b1, 0);

    // Slow memory: 3 idle cycles before every ack.
    ack_delay = 3;
    do_load(32'h840, 32'h5A00_0840, 1'b0, 17);
    do_store(32'h844, 32'h0000_7777, 4);
    do_load(32'h844, 32'h0000_7777, 1'b1, 0);
    ack_delay = 0;

    repeat (3) @(negedge clk);
    check_counters("final");
    check("cpu_q_empty", 66'(cpu_q.size()), 66'd0);
    check("mem_q_empty", 66'(mem_q.size()), 66'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
